ps2_kbd_decoder: RTL and testbench

- Stateful PS/2 Set-2 keyboard front end between the PS/2 serial receiver (one byte per `sc_valid` pulse) and the CPU/console consumer.
- Parses E0/F0/E1 prefixes and tracks modifier state internally, so callers no longer supply shift/ctrl/alt/extend.
- Translates make codes to the team's 8-bit key encoding: ASCII, 0x90-0x99 navigation, 0xA1-0xAC F-keys.
- Buffers results in a parametrised FIFO with a valid/ready output handshake.

---
 rtl/ps2_kbd_pkg.sv | 46 ++++
 rtl/ps2_kbd_decoder_keymap.sv | 85 ++++++++
 rtl/ps2_kbd_decoder.sv | 193 +++++++++++++++++++
 tb/tb_ps2_kbd_decoder.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared constants, key codes, FSM state and FIFO entry layout for the PS/2 keyboard decoder.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_BAT    = 8'hAA;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] KC_UP     = 8'h90;
  localparam logic [7:0] KC_DOWN   = 8'h91;
  localparam logic [7:0] KC_LEFT   = 8'h92;
  localparam logic [7:0] KC_RIGHT  = 8'h93;
  localparam logic [7:0] KC_HOME   = 8'h94;
  localparam logic [7:0] KC_END    = 8'h95;
  localparam logic [7:0] KC_PGUP   = 8'h96;
  localparam logic [7:0] KC_PGDN   = 8'h97;
  localparam logic [7:0] KC_INS    = 8'h98;
  localparam logic [7:0] KC_DEL    = 8'h99;
  localparam logic [7:0] KC_F1     = 8'hA1;
  localparam logic [7:0] KC_F12    = 8'hAC;
  localparam logic [7:0] KC_CAPS   = 8'hAD;

  // Bytes swallowed after E1: the Pause make is eight bytes including the E1 itself.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } ps2_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic [2:0] mods;
    logic       brk;
  } key_entry_t;

endpackage

// File: rtl/ps2_kbd_decoder_keymap.sv
// Combinational Set-2 scancode to key-code table; hit=0 for unmapped codes.
// Letters honour shift^caps and ctrl (ctrl-letter gives 0x01-0x1A); digits honour shift.
module ps2_keymap
  import ps2_kbd_pkg::*;
(
  input  logic [7:0] sc,
  input  logic       ext,
  input  logic       shift,
  input  logic       caps,
  input  logic       ctrl,
  output logic       hit,
  output logic [7:0] code
);

  logic [7:0] base;
  logic [7:0] alt_sym;
  logic       letter;

  always_comb begin
    base    = 8'h00;
    alt_sym = 8'h00;
    if (ext) begin
      case (sc)
        8'h75:   base = KC_UP;
        8'h72:   base = KC_DOWN;
        8'h6B:   base = KC_LEFT;
        8'h74:   base = KC_RIGHT;
        8'h6C:   base = KC_HOME;
        8'h69:   base = KC_END;
        8'h7D:   base = KC_PGUP;
        8'h7A:   base = KC_PGDN;
        8'h70:   base = KC_INS;
        8'h71:   base = KC_DEL;
        default: base = 8'h00;
      endcase
    end else begin
      case (sc)
        8'h1C: base = "a";  8'h32: base = "b";  8'h21: base = "c";  8'h23: base = "d";
        8'h24: base = "e";  8'h2B: base = "f";  8'h34: base = "g";  8'h33: base = "h";
        8'h43: base = "i";  8'h3B: base = "j";  8'h42: base = "k";  8'h4B: base = "l";
        8'h3A: base = "m";  8'h31: base = "n";  8'h44: base = "o";  8'h4D: base = "p";
        8'h15: base = "q";  8'h2D: base = "r";  8'h1B: base = "s";  8'h2C: base = "t";
        8'h3C: base = "u";  8'h2A: base = "v";  8'h1D: base = "w";  8'h22: base = "x";
        8'h35: base = "y";  8'h1A: base = "z";
        8'h16: begin base = "1"; alt_sym = "!"; end
        8'h1E: begin base = "2"; alt_sym = "@"; end
        8'h26: begin base = "3"; alt_sym = "#"; end
        8'h25: begin base = "4"; alt_sym = "$"; end
        8'h2E: begin base = "5"; alt_sym = "%"; end
        8'h36: begin base = "6"; alt_sym = "^"; end
        8'h3D: begin base = "7"; alt_sym = "&"; end
        8'h3E: begin base = "8"; alt_sym = "*"; end
        8'h46: begin base = "9"; alt_sym = "("; end
        8'h45: begin base = "0"; alt_sym = ")"; end
        8'h29: base = 8'h20;
        8'h5A: base = 8'h0D;
        8'h66: base = 8'h08;
        8'h0D: base = 8'h09;
        8'h76: base = 8'h1B;
        8'h05: base = KC_F1;          8'h06: base = KC_F1 + 8'd1;
        8'h04: base = KC_F1 + 8'd2;   8'h0C: base = KC_F1 + 8'd3;
        8'h03: base = KC_F1 + 8'd4;   8'h0B: base = KC_F1 + 8'd5;
        8'h83: base = KC_F1 + 8'd6;   8'h0A: base = KC_F1 + 8'd7;
        8'h01: base = KC_F1 + 8'd8;   8'h09: base = KC_F1 + 8'd9;
        8'h78: base = KC_F1 + 8'd10;  8'h07: base = KC_F12;
        SC_CAPS: base = KC_CAPS;
        default: base = 8'h00;
      endcase
    end
  end

  assign letter = (base >= 8'h61) && (base <= 8'h7A);
  assign hit    = (base != 8'h00);

  always_comb begin
    code = base;
    if (letter) begin
      if (ctrl) code = base & 8'h1F;
      else if (shift ^ caps) code = base - 8'h20;
    end else if (shift && (alt_sym != 8'h00)) begin
      code = alt_sym;
    end
  end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 Set-2 prefix parser, modifier tracker and key-code FIFO; PS2_KBD_CAPSLOCK_EN adds caps-lock.
// Latency: scancode byte in cycle N gives key_valid in N+1 when the FIFO was empty (show-ahead, no bypass).
// Backpressure: head holds while key_ready=0; pushes into a full FIFO without a pop are dropped and flag overflow.
module ps2_kbd_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter bit EMIT_BREAK = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sc_valid,
  input  logic [7:0]                  sc_data,
  output logic                        key_valid,
  input  logic                        key_ready,
  output logic [7:0]                  key_code,
  output logic [2:0]                  key_mods,
  output logic                        key_break,
  output logic                        shift_o,
  output logic                        ctrl_o,
  output logic                        alt_o,
  output logic                        caps_o,
  output logic                        overflow,
  input  logic                        clr_overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  ps2_state_t state;
  logic [2:0] skip_cnt;
  logic       lshift, rshift, lctrl, rctrl, lalt, ralt;
  logic       ext_key, make_ev, brk_ev, bat_ev, is_mod, caps_key;
  logic       km_hit;
  logic [7:0] km_code;
  logic       push_req, push, pop, full;
  key_entry_t wr_entry, head;
  key_entry_t mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign shift_o = lshift | rshift;
  assign ctrl_o  = lctrl | rctrl;
  assign alt_o   = lalt | ralt;

  assign ext_key = (state == ST_EXT) || (state == ST_EXT_BRK);
  assign bat_ev  = sc_valid && (state == ST_IDLE) && (sc_data == SC_BAT);

  always_comb begin
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    if (sc_valid) begin
      case (state)
        ST_IDLE:            make_ev = !(sc_data inside {SC_EXT, SC_BRK, SC_PAUSE, SC_BAT});
        ST_EXT:             make_ev = (sc_data != SC_BRK);
        ST_BRK, ST_EXT_BRK: brk_ev  = 1'b1;
        default:            ;
      endcase
    end
  end

  // E0 12 counts as a modifier so the fake shift is swallowed without effect.
  always_comb begin
    if (ext_key) is_mod = sc_data inside {SC_LSHIFT, SC_CTRL, SC_ALT};
    else         is_mod = sc_data inside {SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_ALT};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      skip_cnt <= 3'd0;
    end else if (sc_valid) begin
      case (state)
        ST_IDLE: begin
          if (sc_data == SC_EXT) state <= ST_EXT;
          else if (sc_data == SC_BRK) state <= ST_BRK;
          else if (sc_data == SC_PAUSE) begin
            state    <= ST_PAUSE;
            skip_cnt <= PAUSE_SKIP;
          end
        end
        ST_EXT:             state <= (sc_data == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
        ST_BRK, ST_EXT_BRK: state <= ST_IDLE;
        ST_PAUSE: begin
          skip_cnt <= skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) state <= ST_IDLE;
        end
        default:            state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {lshift, rshift, lctrl, rctrl, lalt, ralt} <= 6'b0;
    end else if (bat_ev) begin
      {lshift, rshift, lctrl, rctrl, lalt, ralt} <= 6'b0;
    end else if (make_ev || brk_ev) begin
      if (ext_key) begin
        case (sc_data)
          SC_CTRL: rctrl <= make_ev;
          SC_ALT:  ralt  <= make_ev;
          default: ;
        endcase
      end else begin
        case (sc_data)
          SC_LSHIFT: lshift <= make_ev;
          SC_RSHIFT: rshift <= make_ev;
          SC_CTRL:   lctrl  <= make_ev;
          SC_ALT:    lalt   <= make_ev;
          default:   ;
        endcase
      end
    end
  end

`ifdef PS2_KBD_CAPSLOCK_EN
  logic caps_q, caps_held;

  assign caps_key = !ext_key && (sc_data == SC_CAPS) && (make_ev || brk_ev);
  assign caps_o   = caps_q;

  // The held flag blocks typematic repeats of 0x58 from toggling again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      caps_q    <= 1'b0;
      caps_held <= 1'b0;
    end else if (bat_ev) begin
      caps_q    <= 1'b0;
      caps_held <= 1'b0;
    end else if (caps_key) begin
      if (brk_ev) begin
        caps_held <= 1'b0;
      end else if (!caps_held) begin
        caps_q    <= ~caps_q;
        caps_held <= 1'b1;
      end
    end
  end
`else
  assign caps_key = 1'b0;
  assign caps_o   = 1'b0;
`endif

  ps2_keymap u_keymap (
    .sc    (sc_data),
    .ext   (ext_key),
    .shift (shift_o),
    .caps  (caps_o),
    .ctrl  (ctrl_o),
    .hit   (km_hit),
    .code  (km_code)
  );

  assign push_req = km_hit && !is_mod && !caps_key && (make_ev || (brk_ev && EMIT_BREAK));
  assign wr_entry = '{code: km_code, mods: {alt_o, ctrl_o, shift_o}, brk: brk_ev};

  assign full      = (fifo_count == FULL_CNT);
  assign key_valid = (fifo_count != '0);
  assign pop       = key_valid && key_ready;
  assign push      = push_req && (!full || pop);
  assign head      = mem[rd_ptr];

  assign key_code  = key_valid ? head.code : 8'h00;
  assign key_mods  = key_valid ? head.mods : 3'b000;
  assign key_break = key_valid && head.brk;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: ;
      endcase
      if (push_req && full && !pop) overflow <= 1'b1;
      else if (clr_overflow)        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed and randomized bench for ps2_kbd_decoder (FIFO_DEPTH=4, EMIT_BREAK=0).
module tb_ps2_kbd_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sc_valid = 1'b0;
  logic [7:0] sc_data = 8'h00;
  logic       key_ready = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       key_valid, key_break, shift_o, ctrl_o, alt_o, caps_o, overflow;
  logic [7:0] key_code;
  logic [2:0] key_mods;
  logic [2:0] fifo_count;

  ps2_kbd_decoder #(.FIFO_DEPTH(4), .EMIT_BREAK(1'b0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sc_valid     (sc_valid),
    .sc_data      (sc_data),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key_code     (key_code),
    .key_mods     (key_mods),
    .key_break    (key_break),
    .shift_o      (shift_o),
    .ctrl_o       (ctrl_o),
    .alt_o        (alt_o),
    .caps_o       (caps_o),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: which physical keys are held, plus lookup tables of the key layout.
  logic [11:0] expq [$];
  bit          held [6];
  bit          caps_m = 1'b0;
  logic [7:0]  mod_sc  [6]  = '{8'h12, 8'h59, 8'h14, 8'h14, 8'h11, 8'h11};
  bit          mod_ext [6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0]  letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                  8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0]  digit_sc [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
  logic [7:0]  nav_sc [10]   = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};
  logic [7:0]  fk_sc [12]    = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
  logic [7:0]  junk_sc [6]   = '{8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'h75};
  string       digit_ch = "1234567890";
  string       digit_sh = "!@#$%^&*()";

  function automatic logic m_shift(); return held[0] | held[1]; endfunction
  function automatic logic m_ctrl();  return held[2] | held[3]; endfunction
  function automatic logic m_alt();   return held[4] | held[5]; endfunction
  function automatic logic [2:0] m_mods(); return {m_alt(), m_ctrl(), m_shift()}; endfunction

  function automatic logic [7:0] letter_code(input int i);
    if (m_ctrl()) return 8'(i + 1);
    if (m_shift() ^ caps_m) return 8'(65 + i);
    return 8'(97 + i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    sc_data  = b;
    sc_valid = 1'b1;
    @(negedge clk);
    sc_valid = 1'b0;
  endtask

  task automatic press(input logic [7:0] sc, input bit ext);
    if (ext) send(8'hE0);
    send(sc);
  endtask

  task automatic unpress(input logic [7:0] sc, input bit ext);
    if (ext) send(8'hE0);
    send(8'hF0);
    send(sc);
  endtask

  task automatic tap_mod(input int m, input bit down);
    if (down) press(mod_sc[m], mod_ext[m]);
    else      unpress(mod_sc[m], mod_ext[m]);
    held[m] = down;
  endtask

  task automatic expect_code(input logic [7:0] code);
    expq.push_back({code, m_mods(), 1'b0});
  endtask

  task automatic drain();
    logic [11:0] e;
    int          waited;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      waited = 0;
      while (!key_valid && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      chk("head_valid", key_valid, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      chk("key_code", key_code, e[11:4]);
      chk("key_mods", key_mods, e[3:1]);
      chk("key_break", key_break, e[0]);
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
    end
    chk("drained_valid", key_valid, 0);
    chk("drained_count", fifo_count, 0);
  endtask

  task automatic chk_live_mods(input string tag);
    chk({tag, "_mods"}, {alt_o, ctrl_o, shift_o}, m_mods());
    chk({tag, "_caps"}, caps_o, caps_m);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_mods", key_mods, 0);
    chk("rst_break", key_break, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_live", {caps_o, alt_o, ctrl_o, shift_o}, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, k;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Plain make, one-cycle latency, then shifted letter.
    send(8'h1C);
    chk("latency_valid", key_valid, 1);
    chk("latency_count", fifo_count, 1);
    expect_code(8'h61);
    drain();
    tap_mod(0, 1'b1);
    chk_live_mods("lshift_on");
    send(8'h1C);
    expect_code(8'h41);
    tap_mod(0, 1'b0);
    chk_live_mods("lshift_off");
    send(8'h1C);
    expect_code(8'h61);
    drain();

    // Extended make and extended break: only the make is queued.
    press(8'h75, 1'b1);
    unpress(8'h75, 1'b1);
    chk("ext_count", fifo_count, 1);
    expect_code(8'h90);
    send(8'h1C);
    expect_code(8'h61);
    drain();

    // Right ctrl via E0 14, then fake shift E0 12 is ignored.
    tap_mod(3, 1'b1);
    chk_live_mods("rctrl_on");
    press(8'h12, 1'b1);
    chk_live_mods("fake_shift");
    send(8'h1C);
    expect_code(8'h01);
    unpress(8'h12, 1'b1);
    tap_mod(3, 1'b0);
    chk_live_mods("rctrl_off");
    drain();

    // Pause sequence leaves modifiers and queue untouched.
    foreach (nav_sc[i]) if (i == 0) begin end
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk_live_mods("pause");
    chk("pause_count", fifo_count, 0);
    send(8'h16);
    expect_code(8'h31);
    drain();

    // Overflow: four stored, fifth dropped.
    for (int i = 0; i < 5; i++) send(letter_sc[i]);
    chk("full_count", fifo_count, 4);
    chk("full_overflow", overflow, 1);
    chk("full_head", key_code, 8'h61);
    key_ready = 1'b1;
    send(letter_sc[5]);
    key_ready = 1'b0;
    chk("pushpop_count", fifo_count, 4);
    chk("pushpop_head", key_code, 8'h62);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    chk("clr_overflow", overflow, 0);
    clr_overflow = 1'b1;
    send(letter_sc[6]);
    clr_overflow = 1'b0;
    chk("set_wins", overflow, 1);
    chk("set_wins_count", fifo_count, 4);
    expect_code(8'h62); expect_code(8'h63); expect_code(8'h64); expect_code(8'h66);
    drain();

    // Push into empty FIFO with key_ready high: no bypass.
    key_ready = 1'b1;
    send(8'h1C);
    key_ready = 1'b0;
    chk("nobypass_valid", key_valid, 1);
    chk("nobypass_count", fifo_count, 1);

    // Reset mid-prefix with shift held and a queued entry.
    tap_mod(1, 1'b1);
    send(8'hE0);
    rst_n = 1'b0;
    #2;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    held[1] = 1'b0;
    send(8'h75);
    @(negedge clk);
    chk("rst_prefix_valid", key_valid, 0);
    chk("rst_prefix_count", fifo_count, 0);

    // BAT clears held modifiers.
    tap_mod(0, 1'b1);
    tap_mod(4, 1'b1);
    send(8'hAA);
    held[0] = 1'b0;
    held[4] = 1'b0;
    chk_live_mods("bat");

`ifdef PS2_KBD_CAPSLOCK_EN
    send(8'h58); send(8'h58);
    caps_m = 1'b1;
    unpress(8'h58, 1'b0);
    chk_live_mods("caps_once");
    send(8'h1C);
    expect_code(8'h41);
    tap_mod(0, 1'b1);
    send(8'h1C);
    expect_code(8'h61);
    tap_mod(0, 1'b0);
    send(8'h16);
    expect_code(8'h31);
    drain();
`else
    send(8'h58);
    expect_code(8'hAD);
    unpress(8'h58, 1'b0);
    chk_live_mods("no_caps");
    drain();
`endif
    send(8'hAA);
    caps_m = 1'b0;
    foreach (held[i]) held[i] = 1'b0;

    // Randomized key events against the model.
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: begin
          k = $urandom_range(0, 5);
          tap_mod(k, !held[k]);
        end
        1, 2, 3: begin
          k = $urandom_range(0, 25);
          press(letter_sc[k], 1'b0);
          expect_code(letter_code(k));
          unpress(letter_sc[k], 1'b0);
        end
        4: begin
          k = $urandom_range(0, 9);
          press(digit_sc[k], 1'b0);
          expect_code(m_shift() ? digit_sh[k] : digit_ch[k]);
          unpress(digit_sc[k], 1'b0);
        end
        5: begin
          k = $urandom_range(0, 9);
          press(nav_sc[k], 1'b1);
          expect_code(8'(8'h90 + k));
          unpress(nav_sc[k], 1'b1);
        end
        6: begin
          k = $urandom_range(0, 11);
          press(fk_sc[k], 1'b0);
          expect_code(8'(8'hA1 + k));
          unpress(fk_sc[k], 1'b0);
        end
        7: send(junk_sc[$urandom_range(0, 5)]);
        8: begin
          send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
          send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        end
        default: begin
          press(8'h12, 1'b1);
          unpress(8'h12, 1'b1);
        end
      endcase
      chk_live_mods("rand");
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
